// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: datapath widths, reset PC and the fetch entry.
package cpu_defs_pkg;

    localparam int ADDR_W       = 32;
    localparam int INST_W       = 32;
    localparam int MAX_INFLIGHT = 2;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo2.sv
// fifo2: two-entry synchronous FIFO with flush, occupancy count and full/empty flags.
// The head word is presented combinationally on dout; flush drops all entries.
module fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Next-state for storage, pointers and count; a push into a full FIFO is only honoured alongside a pop.
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // State registers; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/if_fetch.sv
// if_fetch: issues in-order fetch requests for the current PC, pairs each response with
// its address, buffers up to two instructions for decode and flushes on a jump.
module if_fetch
    import cpu_defs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr_i,
    input  logic              jump_en_i,
    output logic              stall_o,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    input  logic [INST_W-1:0] rsp_data_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_ready_i
);

    logic [1:0]        inflight_q, inflight_d;
    logic [1:0]        drop_cnt_q, drop_cnt_d;
    logic [2:0]        credit_used;
    logic              req_fire, rsp_live, iq_pop;
    logic [ADDR_W-1:0] aq_head;
    logic [1:0]        aq_count, iq_count;
    logic              aq_full, aq_empty, iq_full, iq_empty;
    fetch_entry_t      iq_din, iq_head;

    // Handshakes, credit check and counter next-state; a jump cycle neither requests nor keeps data.
    always_comb begin
        credit_used  = {1'b0, inflight_q} + {1'b0, iq_count};
        req_valid_o  = !rst && !jump_en_i && (credit_used < 3'(MAX_INFLIGHT));
        req_fire     = req_valid_o && req_ready_i;
        stall_o      = !req_fire && !jump_en_i;
        rsp_live     = rsp_valid_i && !jump_en_i && (drop_cnt_q == 2'd0);
        inst_valid_o = !iq_empty;
        iq_pop       = inst_valid_o && inst_ready_i && !jump_en_i;
        iq_din       = '{addr: aq_head, inst: rsp_data_i};
        inflight_d   = inflight_q + {1'b0, req_fire} - {1'b0, rsp_valid_i};
        if (jump_en_i) begin
            drop_cnt_d = inflight_q - {1'b0, rsp_valid_i};
        end else if (rsp_valid_i && (drop_cnt_q != 2'd0)) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Outstanding-request and stale-response counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 2'd0;
            drop_cnt_q <= 2'd0;
        end else begin
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fifo2 #(.W(ADDR_W)) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_live),
        .flush (jump_en_i),
        .din   (pc_addr_i),
        .dout  (aq_head),
        .count (aq_count),
        .full  (aq_full),
        .empty (aq_empty)
    );

    fifo2 #(.W($bits(fetch_entry_t))) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_live),
        .pop   (iq_pop),
        .flush (jump_en_i),
        .din   (iq_din),
        .dout  (iq_head),
        .count (iq_count),
        .full  (iq_full),
        .empty (iq_empty)
    );

    assign req_addr_o  = pc_addr_i;
    assign inst_o      = iq_head.inst;
    assign inst_addr_o = iq_head.addr;

    // Illegal conditions: the credit rule should make all of these unreachable.
    a_rsp_without_req : assert property (@(posedge clk) disable iff (rst)
        !(rsp_valid_i && (inflight_q == 2'd0)));
    a_iq_overflow : assert property (@(posedge clk) disable iff (rst)
        !(rsp_live && iq_full && !iq_pop));
    a_aq_overflow : assert property (@(posedge clk) disable iff (rst)
        !(req_fire && aq_full && !rsp_live));
    a_aq_underflow : assert property (@(posedge clk) disable iff (rst)
        !(rsp_live && aq_empty));
    a_aq_tracks_live : assert property (@(posedge clk) disable iff (rst)
        (aq_count == (inflight_q - drop_cnt_q)));

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr_i = '0;
    logic        jump_en_i = 1'b0;
    logic        stall_o;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i = 1'b0;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i = 1'b0;

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr_i    (pc_addr_i),
        .jump_en_i    (jump_en_i),
        .stall_o      (stall_o),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_data_i   (rsp_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    int          pops   = 0;
    int          lat    = 1;
    logic [31:0] pc     = '0;
    logic [31:0] jump_tgt = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory returns the oldest request once its latency has elapsed.
    task automatic drive_mem();
        if (mq.size() != 0 && mq[0].due <= cyc_n) begin
            rsp_valid_i = 1'b1;
            rsp_data_i  = mem_data(mq[0].addr);
        end else begin
            rsp_valid_i = 1'b0;
            rsp_data_i  = '0;
        end
    endtask

    // One clock: inputs for the cycle were set at the previous negedge.
    task automatic cyc();
        logic        fire;
        logic [31:0] a;
        logic [31:0] e;
        #1;
        fire = req_valid_o && req_ready_i;
        a    = req_addr_o;
        if (inst_valid_o && inst_ready_i && !jump_en_i) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = 32'hDEAD_BEEF;
            chk("stream_addr", inst_addr_o, e);
            chk("stream_data", inst_o, mem_data(e));
            pops++;
        end
        @(posedge clk);
        if (rsp_valid_i) void'(mq.pop_front());
        if (fire) mq.push_back('{addr: a, due: cyc_n + lat});
        if (jump_en_i) pc = jump_tgt;
        else if (fire) pc = pc + 32'd4;
        cyc_n++;
        @(negedge clk);
        pc_addr_i = pc;
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq.delete();
        exp_q.delete();
        pc = '0;
        pc_addr_i = '0;
        jump_en_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_data_i = '0;
        pops = 0;
        cyc_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_mem();
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int k = 0;
        while (pops < n && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, pops, n);
    endtask

    initial begin
        // reset values while rst is held
        #12;
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_stall", stall_o, 1);
        chk("rst_inst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_inst_addr", inst_addr_o, 0);

        // streaming, 1-cycle memory
        lat = 1; req_ready_i = 1'b1; inst_ready_i = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        #1;
        chk("c0_req_valid", req_valid_o, 1);
        chk("c0_stall", stall_o, 0);
        chk("c0_req_addr", req_addr_o, 32'h0);
        run_until("stream_count", 8, 40);

        // decode back-pressure for 5 cycles
        lat = 1; req_ready_i = 1'b1; inst_ready_i = 1'b0;
        do_reset();
        exp_q = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("bp_req_valid", req_valid_o, 0);
        chk("bp_stall", stall_o, 1);
        chk("bp_inst_valid", inst_valid_o, 1);
        chk("bp_head_addr", inst_addr_o, 32'h0);
        cyc();
        inst_ready_i = 1'b1;
        run_until("bp_release_count", 3, 20);

        // memory back-pressure for 3 cycles, PC held
        lat = 1; req_ready_i = 1'b1; inst_ready_i = 1'b1;
        do_reset();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        cyc();
        cyc();
        req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mbp_stall", stall_o, 1);
            chk("mbp_req_addr", req_addr_o, 32'h8);
            cyc();
        end
        req_ready_i = 1'b1;
        #1;
        chk("mbp_release_stall", stall_o, 0);
        run_until("mbp_count", 4, 20);

        // jump with two requests in flight, 3-cycle memory
        lat = 3; req_ready_i = 1'b1; inst_ready_i = 1'b1;
        do_reset();
        exp_q = '{32'h100, 32'h104, 32'h108};
        cyc();
        cyc();
        jump_en_i = 1'b1; jump_tgt = 32'h100;
        #1;
        chk("jmp_req_valid", req_valid_o, 0);
        chk("jmp_stall", stall_o, 0);
        cyc();
        jump_en_i = 1'b0;
        run_until("jmp_count", 3, 40);

        // jump coincident with a response and a decode pop
        lat = 1; req_ready_i = 1'b1; inst_ready_i = 1'b1;
        do_reset();
        exp_q = '{32'h200, 32'h204, 32'h208};
        cyc();
        cyc();
        #1;
        chk("jpop_pre_valid", inst_valid_o, 1);
        chk("jpop_pre_addr", inst_addr_o, 32'h0);
        jump_en_i = 1'b1; jump_tgt = 32'h200;
        cyc();
        jump_en_i = 1'b0;
        #1;
        chk("jpop_empty", inst_valid_o, 0);
        run_until("jpop_count", 3, 30);

        // jump coincident with a response while another is still outstanding
        lat = 2; req_ready_i = 1'b1; inst_ready_i = 1'b1;
        do_reset();
        exp_q = '{32'h300, 32'h304};
        cyc();
        cyc();
        jump_en_i = 1'b1; jump_tgt = 32'h300;
        cyc();
        jump_en_i = 1'b0;
        #1;
        chk("jrsp_empty", inst_valid_o, 0);
        run_until("jrsp_count", 2, 30);

        // asynchronous reset with two instructions buffered
        lat = 1; req_ready_i = 1'b1; inst_ready_i = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("mrst_pre_valid", inst_valid_o, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_inst_valid", inst_valid_o, 0);
        chk("mrst_inst", inst_o, 0);
        chk("mrst_inst_addr", inst_addr_o, 0);
        chk("mrst_req_valid", req_valid_o, 0);
        chk("mrst_stall", stall_o, 1);
        do_reset();
        inst_ready_i = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        #1;
        chk("mrst_restart_addr", req_addr_o, 32'h0);
        run_until("mrst_count", 3, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
